// File: rtl/grf_wr_arbiter.sv
// Round-robin share of the single GRF write port between two writeback requesters,
// plus a sweep sequencer that zeroes $1..$31. All grf outputs are registered.
module grf_wr_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_wa,
    input  logic [DATA_W-1:0] req0_wd,
    input  logic [DATA_W-1:0] req0_pc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_wa,
    input  logic [DATA_W-1:0] req1_wd,
    input  logic [DATA_W-1:0] req1_pc,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              grf_we,
    output logic [ADDR_W-1:0] grf_wa,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_wpc
);

    // Handshake: a requester transfers when valid & ready at posedge; it holds valid
    // and payload until ready. ready is combinational and never depends on itself.
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;
    logic              rr_last, rr_nx;
    logic              grant0, grant1;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        rr_nx    = rr_last;
        grant0   = 1'b0;
        grant1   = 1'b0;
        case (state)
            IDLE: begin
                // rr_last==1 means req0 wins a tie next.
                grant0 = req0_valid & (~req1_valid | rr_last);
                grant1 = req1_valid & (~req0_valid | ~rr_last);
                if (grant0) rr_nx = 1'b0;
                if (grant1) rr_nx = 1'b1;
                if (clr_start) state_nx = CLEAR;
            end
            CLEAR: begin
                idx_nx = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nx = IDLE;
                    idx_nx   = FIRST_IDX;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Gating with reset keeps readies low while reset is held, so nothing is consumed.
    assign req0_ready = reset & grant0;
    assign req1_ready = reset & grant1;
    assign clr_busy   = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= FIRST_IDX;
            rr_last <= 1'b1;
            grf_we  <= 1'b0;
            grf_wa  <= '0;
            grf_wd  <= '0;
            grf_wpc <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            rr_last <= rr_nx;
            grf_we  <= 1'b0;
            if (state == CLEAR) begin
                grf_we  <= 1'b1;
                grf_wa  <= idx;
                grf_wd  <= '0;
                grf_wpc <= '0;
            end else if (grant0) begin
                // Writes to $0 are consumed but never reach grf.
                if (req0_wa != '0) begin
                    grf_we  <= 1'b1;
                    grf_wa  <= req0_wa;
                    grf_wd  <= req0_wd;
                    grf_wpc <= req0_pc;
                end
            end else if (grant1) begin
                if (req1_wa != '0) begin
                    grf_we  <= 1'b1;
                    grf_wa  <= req1_wa;
                    grf_wd  <= req1_wd;
                    grf_wpc <= req1_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Bench for grf_wr_arbiter: directed scenarios then random traffic, checked against
// a cycle-level reference model feeding an expected-write queue.
module tb_grf_wr_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int EW = AW + 2 * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_wa, req1_wa;
    logic [DW-1:0] req0_wd, req0_pc, req1_wd, req1_pc;
    logic          clr_start, clr_busy;
    logic          grf_we;
    logic [AW-1:0] grf_wa;
    logic [DW-1:0] grf_wd, grf_wpc;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int rr_m = 1;        // last granted requester
    int sweep_left = 0;  // clear cycles still to issue

    grf_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wa(req0_wa),
        .req0_wd(req0_wd), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wa(req1_wa),
        .req1_wd(req1_wd), .req1_pc(req1_pc),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .grf_we(grf_we), .grf_wa(grf_wa), .grf_wd(grf_wd), .grf_wpc(grf_wpc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated once per cycle with inputs stable, before posedge.
    task automatic model_eval(output int grant);
        logic e0, e1;
        grant = -1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!reset) begin
            rr_m = 1;
            sweep_left = 0;
        end else if (sweep_left > 0) begin
            check("clr_busy", EW'(clr_busy), EW'(1));
            exp_q.push_back({AW'(32 - sweep_left), DW'(0), DW'(0)});
            sweep_left--;
        end else begin
            check("clr_busy", EW'(clr_busy), EW'(0));
            if (req0_valid && req1_valid) grant = (rr_m == 0) ? 1 : 0;
            else if (req0_valid) grant = 0;
            else if (req1_valid) grant = 1;
            if (grant == 0) begin
                e0 = 1'b1;
                if (req0_wa != 0) exp_q.push_back({req0_wa, req0_wd, req0_pc});
            end else if (grant == 1) begin
                e1 = 1'b1;
                if (req1_wa != 0) exp_q.push_back({req1_wa, req1_wd, req1_pc});
            end
            if (grant >= 0) rr_m = grant;
            if (clr_start) sweep_left = 31;
        end
        check("req0_ready", EW'(req0_ready), EW'(e0));
        check("req1_ready", EW'(req1_ready), EW'(e1));
        check("both_ready", EW'(req0_ready & req1_ready), EW'(0));
        check("ready_in_clear", EW'((clr_busy === 1'b1) & (req0_ready | req1_ready)), EW'(0));
    endtask

    // One cycle: inputs already driven after negedge; evaluate, advance, retire granted.
    task automatic step();
        int g;
        #1;
        model_eval(g);
        @(negedge clk);
        if (g == 0) req0_valid = 1'b0;
        if (g == 1) req1_valid = 1'b0;
        clr_start = 1'b0;
    endtask

    // Monitor: every grf write must match the head of the expected queue.
    always @(negedge clk) begin
        if (grf_we === 1'b1) begin
            check("wa_nonzero", EW'(grf_wa == 0), EW'(0));
            if (exp_q.size() == 0) begin
                check("spurious_write", {grf_wa, grf_wd, grf_wpc}, '0);
            end else begin
                check("grf_write", {grf_wa, grf_wd, grf_wpc}, exp_q.pop_front());
            end
        end else if (exp_q.size() > 0) begin
            check("missing_write", EW'(grf_we), EW'(1));
            void'(exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        clr_start = 1'b0;
        req0_valid = 1'b1; req0_wa = 5'd3; req0_wd = 32'hAAAA_0000; req0_pc = 32'h0000_1000;
        req1_valid = 1'b1; req1_wa = 5'd4; req1_wd = 32'hBBBB_0000; req1_pc = 32'h0000_2000;
        @(negedge clk);
        step();
        step();
        reset = 1'b1;

        // Both requesters continuously valid: grants must alternate starting with req0.
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Write to $0 is consumed silently, then req0 wins the tie.
        req1_valid = 1'b1; req1_wa = 5'd0; req1_wd = 32'hFFFF_FFFF;
        step();
        req0_valid = 1'b1; req0_wa = 5'd7;
        req1_valid = 1'b1; req1_wa = 5'd8;
        step();
        step();

        // Clear sweep started alongside a req0 write; re-pulse mid-sweep is ignored.
        req0_valid = 1'b1; req0_wa = 5'd5; req0_wd = 32'h1234_5678; req0_pc = 32'h0000_3000;
        clr_start = 1'b1;
        step();
        req1_valid = 1'b1; req1_wa = 5'd9; req1_wd = 32'hCAFE_0009;
        for (int k = 0; k < 31; k++) begin
            if (k == 9) clr_start = 1'b1;
            step();
        end
        step();
        step();

        // Reset in the middle of a sweep abandons it.
        clr_start = 1'b1;
        step();
        for (int k = 0; k < 19; k++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_wa = AW'($urandom_range(0, 31));
                req0_wd = $urandom;
                req0_pc = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_wa = AW'($urandom_range(0, 31));
                req1_wd = $urandom;
                req1_pc = $urandom;
            end
            clr_start = ($urandom_range(0, 80) == 0);
            reset = ($urandom_range(0, 200) != 0);
            step();
        end

        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 40; k++) step();
        check("queue_drained", EW'(exp_q.size()), EW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
